// File: rtl/reset_sequencer.sv
// Staged reset release sequencer. It holds every domain in reset, then releases the domains
// one at a time. Each domain must return its acknowledge before the next domain is released.
// It also supports a soft re-sequence request, and it latches a fault on an ack timeout.
module reset_sequencer #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 8,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_soft_rst_req,
  input  logic [NUM_STAGES-1:0] i_stage_ack,
  output logic [NUM_STAGES-1:0] o_rstn_stage,
  output logic                  o_all_ready,
  output logic                  o_busy,
  output logic                  o_timeout,
  output logic [3:0]            o_fault_stage
);

  localparam int unsigned MaxHg  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned CntMax = (MaxHg > ACK_TIMEOUT) ? MaxHg : ACK_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] HoldLast  = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(STAGE_GAP);
  localparam logic [CntW-1:0] AckLast   = CntW'(ACK_TIMEOUT - 1);
  localparam logic [3:0]      LastStage = 4'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    StAssert,
    StHold,
    StRelease,
    StWaitAck,
    StGap,
    StReady,
    StFault
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [3:0]              k_q, k_d;
  logic [NUM_STAGES-1:0]   rstn_q, rstn_d;
  logic [NUM_STAGES-1:0]   ack_meta_q, ack_s_q;
  logic [NUM_STAGES-1:0]   stage_sel;
  logic                    ack_k;

  // Two-flop synchronizer for the acks returned by the domains.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ack_meta_q <= '0;
      ack_s_q    <= '0;
    end else begin
      ack_meta_q <= i_stage_ack;
      ack_s_q    <= ack_meta_q;
    end
  end

  // One-hot select of the current stage, kept in range for NUM_STAGES < 16.
  always_comb begin
    stage_sel = '0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      stage_sel[i] = (k_q == 4'(i));
    end
  end

  assign ack_k = |(ack_s_q & stage_sel);

  // Sequencer state, counter, stage index and the registered reset outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= StAssert;
      cnt_q   <= '0;
      k_q     <= '0;
      rstn_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      rstn_q  <= rstn_d;
    end
  end

  // Next-state logic. The soft request overrides every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    rstn_d  = rstn_q;
    if (i_soft_rst_req) begin
      state_d = StAssert;
      cnt_d   = '0;
      k_d     = '0;
      rstn_d  = '0;
    end else begin
      unique case (state_q)
        StAssert: begin
          cnt_d   = '0;
          k_d     = '0;
          rstn_d  = '0;
          state_d = StHold;
        end
        StHold: begin
          if (cnt_q == HoldLast) begin
            cnt_d   = '0;
            state_d = StRelease;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRelease: begin
          rstn_d  = rstn_q | stage_sel;
          cnt_d   = '0;
          state_d = StWaitAck;
        end
        StWaitAck: begin
          // The first WAIT_ACK cycle ignores the ack, so the freshly released rstn can reach the
          // domain. An ack on the final counted cycle still beats the timeout.
          if (ack_k && (cnt_q != '0)) begin
            cnt_d   = '0;
            state_d = (k_q == LastStage) ? StReady : StGap;
          end else if (cnt_q == AckLast) begin
            state_d = StFault;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            cnt_d   = '0;
            k_d     = k_q + 1'b1;
            state_d = StRelease;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StReady: begin
          // A domain that drops its ack forces a full re-sequence.
          if (ack_s_q != '1) begin
            rstn_d  = '0;
            state_d = StAssert;
          end
        end
        StFault: begin
          state_d = StFault;
        end
        default: begin
          state_d = StAssert;
        end
      endcase
    end
  end

  assign o_rstn_stage  = rstn_q;
  assign o_all_ready   = (state_q == StReady);
  assign o_busy        = (state_q != StReady) && (state_q != StFault);
  assign o_timeout     = (state_q == StFault);
  assign o_fault_stage = (state_q == StFault) ? k_q : 4'd0;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer.
// dut_a: GAP=8, TIMEOUT=64, with acks equal to the released stages delayed by 3 cycles.
// dut_b: GAP=0, TIMEOUT=64, with acks driven directly.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rstn_a = 1'b0, rstn_b = 1'b0;
  logic       soft_a = 1'b0, soft_b = 1'b0;
  logic [3:0] kill_a = 4'h0;
  logic [3:0] ack_a;
  logic [3:0] ack_b = 4'hF;
  logic [3:0] d1 = 4'h0, d2 = 4'h0, d3 = 4'h0;
  logic [3:0] rs_a, rs_b, fs_a, fs_b;
  logic       ready_a, busy_a, to_a, ready_b, busy_b, to_b;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  // Domain model: ack follows the released reset 3 cycles later, optionally masked.
  always @(posedge clk) begin
    d1 <= rs_a;
    d2 <= d1;
    d3 <= d2;
  end
  assign ack_a = d3 & ~kill_a;

  reset_sequencer #(
    .NUM_STAGES (4),
    .HOLD_CYCLES(16),
    .STAGE_GAP  (8),
    .ACK_TIMEOUT(64)
  ) dut_a (
    .i_clk         (clk),
    .i_rstn        (rstn_a),
    .i_soft_rst_req(soft_a),
    .i_stage_ack   (ack_a),
    .o_rstn_stage  (rs_a),
    .o_all_ready   (ready_a),
    .o_busy        (busy_a),
    .o_timeout     (to_a),
    .o_fault_stage (fs_a)
  );

  reset_sequencer #(
    .NUM_STAGES (4),
    .HOLD_CYCLES(16),
    .STAGE_GAP  (0),
    .ACK_TIMEOUT(64)
  ) dut_b (
    .i_clk         (clk),
    .i_rstn        (rstn_b),
    .i_soft_rst_req(soft_b),
    .i_stage_ack   (ack_b),
    .o_rstn_stage  (rs_b),
    .o_all_ready   (ready_b),
    .o_busy        (busy_b),
    .o_timeout     (to_b),
    .o_fault_stage (fs_b)
  );

  // Counts negedges until the stage vector equals v. Returns -1 if the bound expires.
  task automatic wait_rstn(input bit use_b, input logic [3:0] v, input int bound, output int n);
    n = 0;
    while (((use_b ? rs_b : rs_a) !== v) && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    if ((use_b ? rs_b : rs_a) !== v) n = -1;
  endtask

  task automatic wait_ready(input bit use_b, input int bound, output int n);
    n = 0;
    while (((use_b ? ready_b : ready_a) !== 1'b1) && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    if ((use_b ? ready_b : ready_a) !== 1'b1) n = -1;
  endtask

  task automatic wait_timeout_a(input int bound, output int n);
    n = 0;
    while ((to_a !== 1'b1) && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    if (to_a !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    checks++; if (rs_a !== 4'h0) begin fails++; $display("FAIL reset_rstn: got %b want 0000", rs_a); end
    checks++; if (ready_a !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", ready_a); end
    checks++; if (busy_a !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b want 1", busy_a); end
    checks++; if (to_a !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b want 0", to_a); end
    checks++; if (fs_a !== 4'h0) begin fails++; $display("FAIL reset_fault_stage: got %0d want 0", fs_a); end
  endtask

  task automatic test_sequence();
    logic [3:0] exp_v [4];
    int n;
    exp_v = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    rstn_a = 1'b1;
    // Stage 0 rises HOLD+1 edges after the first edge. The sample after that first edge is n=1.
    wait_rstn(1'b0, exp_v[0], 40, n);
    checks++; if (n !== 18) begin fails++; $display("FAIL seq_stage0_latency: got %0d want 18", n); end
    // With acks delayed by 3 cycles and 2 sync flops: WAIT 6 + GAP 9 + RELEASE 1 = 16.
    for (int s = 1; s < 4; s++) begin
      wait_rstn(1'b0, exp_v[s], 40, n);
      checks++;
      if (n !== 16) begin fails++; $display("FAIL seq_stage%0d_spacing: got %0d want 16", s, n); end
    end
    wait_ready(1'b0, 40, n);
    checks++; if (n !== 6) begin fails++; $display("FAIL seq_ready_latency: got %0d want 6", n); end
    checks++; if (to_a !== 1'b0) begin fails++; $display("FAIL seq_timeout: got %b want 0", to_a); end
    checks++; if (busy_a !== 1'b0) begin fails++; $display("FAIL seq_busy: got %b want 0", busy_a); end
  endtask

  task automatic test_lost_ack();
    int n;
    kill_a = 4'b0010;
    @(negedge clk);
    kill_a = 4'b0000;
    n = 1;
    while (ready_a && (n < 10)) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 3) begin fails++; $display("FAIL lost_ack_ready_fall: got %0d want 3", n); end
    checks++; if (rs_a !== 4'h0) begin fails++; $display("FAIL lost_ack_rstn: got %b want 0000", rs_a); end
    wait_rstn(1'b0, 4'b0001, 40, n);
    checks++; if (n !== 18) begin fails++; $display("FAIL lost_ack_stage0: got %0d want 18", n); end
    wait_ready(1'b0, 120, n);
    checks++; if (n < 0) begin fails++; $display("FAIL lost_ack_reready: got %0d want >=0", n); end
    checks++; if (rs_a !== 4'hF) begin fails++; $display("FAIL lost_ack_rstn_final: got %b want 1111", rs_a); end
  endtask

  task automatic test_timeout();
    int n;
    kill_a = 4'b0100;
    wait_rstn(1'b0, 4'b0000, 10, n);
    wait_rstn(1'b0, 4'b0111, 120, n);
    checks++; if (n < 0) begin fails++; $display("FAIL timeout_reach_stage2: got %0d want >=0", n); end
    wait_timeout_a(100, n);
    checks++; if (n !== 64) begin fails++; $display("FAIL timeout_latency: got %0d want 64", n); end
    checks++; if (fs_a !== 4'd2) begin fails++; $display("FAIL timeout_fault_stage: got %0d want 2", fs_a); end
    checks++; if (rs_a !== 4'b0111) begin fails++; $display("FAIL timeout_rstn: got %b want 0111", rs_a); end
    checks++; if (busy_a !== 1'b0) begin fails++; $display("FAIL timeout_busy: got %b want 0", busy_a); end
    checks++; if (ready_a !== 1'b0) begin fails++; $display("FAIL timeout_ready: got %b want 0", ready_a); end
    // A soft request clears the fault on the next cycle.
    soft_a = 1'b1;
    @(negedge clk);
    checks++; if (to_a !== 1'b0) begin fails++; $display("FAIL soft_clr_timeout: got %b want 0", to_a); end
    checks++; if (fs_a !== 4'd0) begin fails++; $display("FAIL soft_clr_fault_stage: got %0d want 0", fs_a); end
    checks++; if (rs_a !== 4'h0) begin fails++; $display("FAIL soft_clr_rstn: got %b want 0000", rs_a); end
    checks++; if (busy_a !== 1'b1) begin fails++; $display("FAIL soft_clr_busy: got %b want 1", busy_a); end
    kill_a = 4'b0000;
    repeat (3) @(negedge clk);
    soft_a = 1'b0;
    wait_ready(1'b0, 120, n);
    checks++; if (n < 0) begin fails++; $display("FAIL soft_clr_reready: got %0d want >=0", n); end
  endtask

  task automatic test_soft_reset();
    int n;
    soft_a = 1'b1;
    @(negedge clk);
    checks++; if (rs_a !== 4'h0) begin fails++; $display("FAIL soft_rstn: got %b want 0000", rs_a); end
    checks++; if (ready_a !== 1'b0) begin fails++; $display("FAIL soft_ready: got %b want 0", ready_a); end
    repeat (9) @(negedge clk);
    checks++; if (rs_a !== 4'h0) begin fails++; $display("FAIL soft_hold_rstn: got %b want 0000", rs_a); end
    soft_a = 1'b0;
    wait_rstn(1'b0, 4'b0001, 40, n);
    checks++; if (n !== 18) begin fails++; $display("FAIL soft_stage0: got %0d want 18", n); end
    wait_ready(1'b0, 120, n);
    checks++; if (n < 0) begin fails++; $display("FAIL soft_reready: got %0d want >=0", n); end
    checks++; if (to_a !== 1'b0) begin fails++; $display("FAIL soft_timeout: got %b want 0", to_a); end
  endtask

  task automatic test_async_reset();
    int n;
    soft_a = 1'b1;
    @(negedge clk);
    soft_a = 1'b0;
    wait_rstn(1'b0, 4'b0011, 60, n);
    checks++; if (n < 0) begin fails++; $display("FAIL async_reach_stage1: got %0d want >=0", n); end
    repeat (8) @(negedge clk);  // now inside the GAP after stage 1 was acked
    #2 rstn_a = 1'b0;
    #1;
    checks++; if (rs_a !== 4'h0) begin fails++; $display("FAIL async_rstn: got %b want 0000", rs_a); end
    checks++; if (busy_a !== 1'b1) begin fails++; $display("FAIL async_busy: got %b want 1", busy_a); end
    checks++; if (ready_a !== 1'b0) begin fails++; $display("FAIL async_ready: got %b want 0", ready_a); end
    repeat (4) @(negedge clk);
    rstn_a = 1'b1;
    wait_rstn(1'b0, 4'b0001, 40, n);
    checks++; if (n !== 18) begin fails++; $display("FAIL async_stage0: got %0d want 18", n); end
    wait_ready(1'b0, 120, n);
    checks++; if (n < 0) begin fails++; $display("FAIL async_reready: got %0d want >=0", n); end
  endtask

  task automatic test_gap0();
    logic [3:0] exp_v [4];
    int n;
    exp_v = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    rstn_b = 1'b1;
    wait_rstn(1'b1, exp_v[0], 40, n);
    checks++; if (n !== 18) begin fails++; $display("FAIL gap0_stage0: got %0d want 18", n); end
    for (int s = 1; s < 4; s++) begin
      wait_rstn(1'b1, exp_v[s], 20, n);
      checks++;
      if (n !== 4) begin fails++; $display("FAIL gap0_stage%0d_spacing: got %0d want 4", s, n); end
    end
    wait_ready(1'b1, 20, n);
    checks++; if (n !== 2) begin fails++; $display("FAIL gap0_ready: got %0d want 2", n); end
    checks++; if (to_b !== 1'b0) begin fails++; $display("FAIL gap0_timeout: got %b want 0", to_b); end
  endtask

  task automatic test_ack_at_expiry();
    int n;
    ack_b = 4'b0011;
    wait_rstn(1'b1, 4'b0000, 10, n);
    wait_rstn(1'b1, 4'b0111, 60, n);
    checks++; if (n < 0) begin fails++; $display("FAIL expiry_reach_stage2: got %0d want >=0", n); end
    // The ack reaches the sync output in time for the 64th WAIT_ACK cycle. Stage 3 is acked early.
    repeat (61) @(negedge clk);
    ack_b = 4'hF;
    wait_rstn(1'b1, 4'hF, 20, n);
    checks++; if (n !== 5) begin fails++; $display("FAIL expiry_stage3: got %0d want 5", n); end
    checks++; if (to_b !== 1'b0) begin fails++; $display("FAIL expiry_no_fault: got %b want 0", to_b); end
    wait_ready(1'b1, 20, n);
    checks++; if (n !== 2) begin fails++; $display("FAIL expiry_ready: got %0d want 2", n); end
    checks++; if (to_b !== 1'b0) begin fails++; $display("FAIL expiry_timeout_end: got %b want 0", to_b); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_lost_ack();
    test_timeout();
    test_soft_reset();
    test_async_reset();
    test_gap0();
    test_ack_at_expiry();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
